// File: rtl/seq_scan_controller.sv
// Serialises a latched word MSB-first and scores a PAT_W-bit Moore pattern match
// on the stream, reporting the hit count with a one-cycle done pulse.
module seq_scan_controller #(
    parameter int unsigned WORD_W = 20,
    parameter int unsigned PAT_W  = 4,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              overlap,
    output logic              x_out,
    output logic              x_valid,
    output logic              hit,
    output logic [CNT_W-1:0]  hit_count,
    output logic              done,
    output logic              busy
);

    localparam int unsigned IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_REPORT
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [PAT_W-1:0]    pat_q, pat_d;
    logic                ovl_q, ovl_d;
    logic [PAT_W-1:0]    hist_q, hist_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                hit_q, hit_d;

    logic [FILL_W-1:0]   fill_inc;
    logic                match;

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        pat_d    = pat_q;
        ovl_d    = ovl_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        hit_d    = hit_q;
        fill_inc = fill_q;
        match    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    word_d  = in_word;
                    pat_d   = pattern;
                    ovl_d   = overlap;
                    hist_d  = '0;
                    fill_d  = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    hit_d   = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The bit on x_out this cycle enters the history at the edge.
                hist_d   = {hist_q[PAT_W-2:0], word_q[WORD_W-1]};
                word_d   = {word_q[WORD_W-2:0], 1'b0};
                fill_inc = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
                match    = (fill_inc == FILL_W'(PAT_W)) && (hist_d == pat_q);
                hit_d    = match;
                if (match && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Non-overlapping mode demands PAT_W fresh bits after each hit.
                fill_d = (match && !ovl_q) ? '0 : fill_inc;
                idx_d  = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(WORD_W - 1)) begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                hit_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
        end
    end

    // Outputs are forced low for the whole time rst is asserted, not just after its edge.
    assign in_ready  = !rst && (state_q == ST_IDLE);
    assign x_valid   = !rst && (state_q == ST_SHIFT);
    assign x_out     = !rst && (state_q == ST_SHIFT) && word_q[WORD_W-1];
    assign hit       = !rst && hit_q;
    assign done      = !rst && (state_q == ST_REPORT);
    assign busy      = !rst && (state_q != ST_IDLE);
    assign hit_count = rst ? '0 : cnt_q;

endmodule
